// File: rtl/id_ex_hazard_register.sv
// ============================================================================
// id_ex_hazard_register
// ----------------------------------------------------------------------------
// ID/EX pipeline register of the 5-stage MIPS core, fused with load-use hazard
// detection. The decoded instruction in ID is captured on each rising clock
// edge and presented to EX one cycle later. The module recognises a load in
// EX whose destination is a source of the instruction in ID. When it sees one,
// it holds PC and IF/ID for one cycle and loads a bubble into EX.
//
// A taken branch/jump (i_flush) squashes the ID instruction into a bubble.
// A downstream stall (i_hold) freezes the whole register and also holds PC and
// IF/ID. The order of precedence is reset > hold > flush > load-use > normal
// capture.
//
// A bubble is all zeros. Its register numbers are $zero and RegWrite is 0, so
// the forwarding unit can never match it.
//
// Optional feature (macro HAZARD_STATS_EN):
//   Adds two free-running 32-bit event counters, o_stall_count and
//   o_flush_count. Both clear on reset and wrap modulo 2^32. With the macro
//   undefined, these ports and counters do not exist.
//
// Ports:
//   clk                  in   pipeline clock, rising edge
//   reset                in   synchronous, active-high reset
//   i_if_id_rs/rt/rd     in   5   register numbers of the ID instruction
//   i_if_id_read_data1/2 in   N   register file read ports
//   i_if_id_imm          in   N   sign-extended immediate
//   i_if_id_pc4          in   N   PC+4 of the ID instruction
//   i_if_id_mem_read     in   1   ID instruction is a load
//   i_if_id_reg_write    in   1   ID instruction writes the register file
//   i_if_id_ctrl         in   CTRL_W  opaque EX/MEM/WB control bits
//   i_flush              in   1   squash the ID instruction
//   i_hold               in   1   freeze the register (downstream stall)
//   o_id_ex_*            out      registered copies of the above
//   o_id_ex_valid        out  1   1 = real instruction, 0 = bubble
//   o_pc_write           out  1   0 = hold PC this cycle
//   o_if_id_write        out  1   0 = hold IF/ID this cycle
//   o_stall_count        out  32  load-use bubbles inserted (HAZARD_STATS_EN)
//   o_flush_count        out  32  flushes taken (HAZARD_STATS_EN)
// ============================================================================
module id_ex_hazard_register #(
    parameter int N      = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [4:0]        i_if_id_rs,
    input  logic [4:0]        i_if_id_rt,
    input  logic [4:0]        i_if_id_rd,
    input  logic [N-1:0]      i_if_id_read_data1,
    input  logic [N-1:0]      i_if_id_read_data2,
    input  logic [N-1:0]      i_if_id_imm,
    input  logic [N-1:0]      i_if_id_pc4,
    input  logic              i_if_id_mem_read,
    input  logic              i_if_id_reg_write,
    input  logic [CTRL_W-1:0] i_if_id_ctrl,
    input  logic              i_flush,
    input  logic              i_hold,

    output logic [4:0]        o_id_ex_rs,
    output logic [4:0]        o_id_ex_rt,
    output logic [4:0]        o_id_ex_rd,
    output logic [N-1:0]      o_id_ex_read_data1,
    output logic [N-1:0]      o_id_ex_read_data2,
    output logic [N-1:0]      o_id_ex_imm,
    output logic [N-1:0]      o_id_ex_pc4,
    output logic              o_id_ex_mem_read,
    output logic              o_id_ex_reg_write,
    output logic [CTRL_W-1:0] o_id_ex_ctrl,
    output logic              o_id_ex_valid,
    output logic              o_pc_write,
    output logic              o_if_id_write
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       o_stall_count,
    output logic [31:0]       o_flush_count
`endif
);

    // ------------------------------------------------------------------------
    // Stage contents. The register is one packed word, so a bubble is '0 and
    // a capture is a single assignment.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [N-1:0]      read_data1;
        logic [N-1:0]      read_data2;
        logic [N-1:0]      imm;
        logic [N-1:0]      pc4;
        logic              mem_read;
        logic              reg_write;
        logic [CTRL_W-1:0] ctrl;
        logic              valid;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    stage_t r_stage;
    stage_t w_id_stage;
    stage_t w_next_stage;
    logic   w_load_use;
    logic   w_rt_nonzero;
    logic   w_src_match;

    // The ID instruction packaged as a valid stage entry.
    always_comb begin
        w_id_stage            = BUBBLE;
        w_id_stage.rs         = i_if_id_rs;
        w_id_stage.rt         = i_if_id_rt;
        w_id_stage.rd         = i_if_id_rd;
        w_id_stage.read_data1 = i_if_id_read_data1;
        w_id_stage.read_data2 = i_if_id_read_data2;
        w_id_stage.imm        = i_if_id_imm;
        w_id_stage.pc4        = i_if_id_pc4;
        w_id_stage.mem_read   = i_if_id_mem_read;
        w_id_stage.reg_write  = i_if_id_reg_write;
        w_id_stage.ctrl       = i_if_id_ctrl;
        w_id_stage.valid      = 1'b1;
    end

    // ------------------------------------------------------------------------
    // Load-use detection: a valid load in EX writes a register that the ID
    // instruction reads. A load to $zero never stalls. That register is
    // hard-wired to 0, so there is nothing to wait for.
    // ------------------------------------------------------------------------
    assign w_rt_nonzero = (r_stage.rt != 5'd0);
    assign w_src_match  = (r_stage.rt == i_if_id_rs) | (r_stage.rt == i_if_id_rt);
    assign w_load_use   = r_stage.mem_read & r_stage.valid & w_rt_nonzero & w_src_match;

    // PC and IF/ID advance only when EX can accept the ID instruction. During
    // reset the front end is left free-running.
    always_comb begin
        o_pc_write    = 1'b1;
        o_if_id_write = 1'b1;
        if (!reset) begin
            o_pc_write    = ~(w_load_use | i_hold);
            o_if_id_write = ~(w_load_use | i_hold);
        end
    end

    // Next stage contents for a clock edge without reset or hold. Flush and
    // load-use both produce one bubble, so checking them together also makes
    // flush dominate when both are present.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned; an unassigned path would infer a latch.
        w_next_stage = w_id_stage;
        if (i_flush || w_load_use) begin
            w_next_stage = BUBBLE;
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline register. Reset is sampled on the clock edge only.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // flop samples pre-edge values, independent of block ordering.
        if (reset) begin
            r_stage <= BUBBLE;
        end else if (!i_hold) begin
            r_stage <= w_next_stage;
        end
    end

    assign o_id_ex_rs         = r_stage.rs;
    assign o_id_ex_rt         = r_stage.rt;
    assign o_id_ex_rd         = r_stage.rd;
    assign o_id_ex_read_data1 = r_stage.read_data1;
    assign o_id_ex_read_data2 = r_stage.read_data2;
    assign o_id_ex_imm        = r_stage.imm;
    assign o_id_ex_pc4        = r_stage.pc4;
    assign o_id_ex_mem_read   = r_stage.mem_read;
    assign o_id_ex_reg_write  = r_stage.reg_write;
    assign o_id_ex_ctrl       = r_stage.ctrl;
    assign o_id_ex_valid      = r_stage.valid;

    // ------------------------------------------------------------------------
    // Optional hazard statistics. A stall counts only when its bubble really
    // lands: hold suppresses the bubble, and flush takes precedence over it.
    // ------------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else begin
            if (w_load_use && !i_hold && !i_flush) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (i_flush && !i_hold) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;
`else
    // Statistics disabled: no counter ports or state.
`endif

endmodule

// File: doc/id_ex_hazard_register.md
Name: id_ex_hazard_register

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, fused with load-use hazard detection.
- Captures decoded operands, register numbers and control from ID, and presents them to EX.
- Its ID_EX_Rs, ID_EX_Rt and RegWrite/Rd feed the forwarding unit.
- On a load-use hazard it stalls PC and IF/ID for one cycle and inserts a bubble. It also honours branch/jump flush and a downstream hold.

Parameters:
- N, 32, datapath width (read data, sign-extended immediate, PC+4).
- CTRL_W, 8, width of the opaque EX/MEM/WB control bus passed through unchanged.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- IF_ID_Rs  input  5  rs field of the instruction currently in ID.
- IF_ID_Rt  input  5  rt field of the instruction currently in ID.
- IF_ID_Rd  input  5  destination chosen in ID (rd/rt/31 for JAL).
- IF_ID_ReadData1  input  N  register file port 1.
- IF_ID_ReadData2  input  N  register file port 2.
- IF_ID_Imm  input  N  sign-extended immediate.
- IF_ID_PC4  input  N  PC+4 of the ID instruction.
- IF_ID_MemRead  input  1  ID instruction is a load.
- IF_ID_RegWrite  input  1  ID instruction writes the register file.
- IF_ID_Ctrl  input  CTRL_W  remaining control bits.
- Flush  input  1  branch/jump taken; squash the ID instruction.
- Hold  input  1  downstream stall; freeze the register.
- ID_EX_Rs, ID_EX_Rt, ID_EX_Rd  output  5  registered register numbers.
- ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC4  output  N  registered data.
- ID_EX_MemRead, ID_EX_RegWrite  output  1  registered control.
- ID_EX_Ctrl  output  CTRL_W  registered control bus.
- ID_EX_Valid  output  1  1 = real instruction, 0 = bubble.
- PCWrite  output  1  0 = hold PC this cycle.
- IF_ID_Write  output  1  0 = hold IF/ID this cycle.

Behaviour:
- Reset: all registered outputs are 0, including ID_EX_Valid. Reset has priority over everything and is evaluated only on the clk edge.
- Hazard (combinational, from registered state and current inputs): LoadUse = ID_EX_MemRead & ID_EX_Valid & (ID_EX_Rt != 0) & ((ID_EX_Rt == IF_ID_Rs) | (ID_EX_Rt == IF_ID_Rt)).
- PCWrite = IF_ID_Write = ~(LoadUse | Hold).
- While reset is asserted, PCWrite and IF_ID_Write are driven 1.
- Register update on each rising clk, priority order:
  1. reset: clear all registered outputs.
  2. Hold: all registers keep their value; no bubble is inserted.
  3. Flush: load a bubble.
  4. LoadUse: load a bubble.
  5. Otherwise: load all IF_ID_* inputs and set Valid = 1.
- Bubble contents: Rs, Rt and Rd = 0; MemRead, RegWrite and Ctrl = 0; Valid = 0; data fields = 0. Forwarding therefore never matches a bubble.
- Latency: one cycle from ID input to ID_EX output.
- A load-use stall lasts exactly one cycle. After the bubble, ID_EX_MemRead = 0, so LoadUse deasserts and the stalled instruction enters on the next edge.
- Flush and LoadUse in the same cycle: a single bubble; Flush dominates.
- Hold and Flush in the same cycle: Hold wins. Flush must be re-asserted by its source until Hold drops.
- A back-to-back load followed by a dependent load gives one bubble per dependent pair. No multi-cycle state is retained.
- Rt = 0 (or Rs = 0) in ID never causes a stall against $zero.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined: adds outputs StallCount (32) and FlushCount (32).
  - StallCount increments on each edge where LoadUse & ~Hold & ~Flush.
  - FlushCount increments on each edge where Flush & ~Hold.
  - Both clear on reset and wrap modulo 2^32.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert reset for 2 cycles with nonzero inputs -> all ID_EX_* = 0, Valid = 0, PCWrite = 1, IF_ID_Write = 1.
- Normal flow: add $3,$1,$2 (Rs=1, Rt=2, Rd=3, RegWrite=1) -> after 1 edge ID_EX_Rs=1, Rt=2, Rd=3, RegWrite=1, Valid=1; PCWrite stays 1.
- Load-use: lw $5,0($1) in EX (MemRead=1, Rt=5), then add $6,$5,$2 in ID -> PCWrite=0 and IF_ID_Write=0 for exactly 1 cycle; next edge loads a bubble (Rd=0, RegWrite=0, Valid=0); the following edge loads add with Rs=5.
- Zero register: lw $0 in EX with IF_ID_Rs=0 -> no stall, PCWrite=1.
- Flush: Flush=1 while ID holds sw with Rt=7 -> ID_EX_Valid=0, Ctrl=0, Rt=0. With HAZARD_STATS_EN, FlushCount goes 0 -> 1.
- Hold priority: Hold=1 together with Flush=1 for 3 cycles, ID_EX holding Rd=9 -> outputs unchanged (Rd=9, Valid=1); PCWrite=0 throughout; counters unchanged.
